// File: rtl/pc_phase_sequencer.sv
// Fetch/phase sequencer and program counter for the multi-cycle RV32 core.
// Fetches, latches, steps execute phases, then retires and advances the PC.
module pc_phase_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000,
    parameter int              PC_INC       = 4,
    parameter int              NUM_PHASES   = 3,
    parameter int              WB_PHASE     = 1,
    parameter int              ALIGN_CHECK  = 1,
    parameter int              CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             fetch_valid,
    input  logic             fetch_ready,
    output logic [XLEN-1:0]  fetch_addr,
    input  logic             inst_rvalid,
    input  logic [XLEN-1:0]  inst_rdata,
    output logic [XLEN-1:0]  inst,
    input  logic             stall,
    input  logic             redirect_en,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             halt_req,
    output logic [3:0]       phase,
    output logic             wb_strobe,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus_inc,
    output logic             busy,
    output logic             halted,
    output logic             misalign_err,
    output logic [CNT_W-1:0] retire_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_HALTED,
        S_ERROR
    } state_t;

    localparam logic [3:0] LAST_PH = 4'(NUM_PHASES - 1);
    localparam logic [3:0] WB_PH   = 4'(WB_PHASE);

    state_t            state, state_nxt;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   inst_q;
    logic [3:0]        phase_q;
    logic [CNT_W-1:0]  retire_q;
    logic [XLEN-1:0]   next_pc;
    logic              in_exec;
    logic              adv;
    logic              is_last;
    logic              bad_align;

    assign pc_plus_inc = pc_q + XLEN'(PC_INC);
    assign next_pc     = redirect_en ? redirect_target : pc_plus_inc;
    assign in_exec     = (state == S_EXEC);
    assign adv         = in_exec && !stall;
    assign is_last     = (phase_q == LAST_PH);
    assign bad_align   = (ALIGN_CHECK != 0) && (next_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  state_nxt = S_FETCH;
            S_FETCH: if (fetch_ready) state_nxt = S_WAIT;
            S_WAIT:  if (inst_rvalid) state_nxt = S_EXEC;
            S_EXEC: begin
                if (!stall && is_last) begin
                    if (bad_align)     state_nxt = S_ERROR;
                    else if (halt_req) state_nxt = S_HALTED;
                    else               state_nxt = S_FETCH;
                end
            end
            S_HALTED: state_nxt = S_HALTED;
            S_ERROR:  state_nxt = S_ERROR;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // A misaligned next-PC leaves pc and the retire count untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_VECTOR;
            inst_q   <= '0;
            phase_q  <= '0;
            retire_q <= '0;
        end else begin
            if (state == S_WAIT && inst_rvalid) begin
                inst_q  <= inst_rdata;
                phase_q <= '0;
            end
            if (adv) begin
                if (!is_last) begin
                    phase_q <= phase_q + 4'd1;
                end else if (!bad_align) begin
                    pc_q     <= next_pc;
                    retire_q <= retire_q + CNT_W'(1);
                    phase_q  <= '0;
                end
            end
        end
    end

    always_comb begin
        fetch_valid  = (state == S_FETCH);
        fetch_addr   = pc_q;
        busy         = (state == S_FETCH) || (state == S_WAIT) || in_exec;
        halted       = (state == S_HALTED);
        misalign_err = (state == S_ERROR);
        phase        = in_exec ? phase_q : 4'd0;
        wb_strobe    = adv && (phase_q == WB_PH);
    end

    assign pc           = pc_q;
    assign inst         = inst_q;
    assign retire_count = retire_q;

endmodule

// File: tb/tb_pc_phase_sequencer.sv
// Directed bench for pc_phase_sequencer: default 3-phase instance plus
// a 4-phase instance with writeback on the final phase.
module tb_pc_phase_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid, fetch_ready;
    logic [31:0] fetch_addr;
    logic        inst_rvalid;
    logic [31:0] inst_rdata, inst;
    logic        stall, redirect_en, halt_req;
    logic [31:0] redirect_target;
    logic [3:0]  phase;
    logic        wb_strobe;
    logic [31:0] pc, pc_plus_inc;
    logic        busy, halted, misalign_err;
    logic [31:0] retire_count;

    logic        r4, fv4, fr4, rv4, wb4, busy4, hlt4, err4;
    logic [31:0] fa4, inst4, pc4, ppi4, rc4;
    logic [3:0]  ph4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_phase_sequencer dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_addr(fetch_addr),
        .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata), .inst(inst),
        .stall(stall), .redirect_en(redirect_en),
        .redirect_target(redirect_target), .halt_req(halt_req),
        .phase(phase), .wb_strobe(wb_strobe),
        .pc(pc), .pc_plus_inc(pc_plus_inc),
        .busy(busy), .halted(halted), .misalign_err(misalign_err),
        .retire_count(retire_count)
    );

    pc_phase_sequencer #(.NUM_PHASES(4), .WB_PHASE(3)) dut4 (
        .clk(clk), .rst(r4),
        .fetch_valid(fv4), .fetch_ready(fr4), .fetch_addr(fa4),
        .inst_rvalid(rv4), .inst_rdata(32'h0000_0013), .inst(inst4),
        .stall(1'b0), .redirect_en(1'b0),
        .redirect_target(32'h0), .halt_req(1'b0),
        .phase(ph4), .wb_strobe(wb4),
        .pc(pc4), .pc_plus_inc(ppi4),
        .busy(busy4), .halted(hlt4), .misalign_err(err4),
        .retire_count(rc4)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fetch_seq(input logic [31:0] a, input logic [31:0] d);
        chk("fetch_valid", 64'(fetch_valid), 64'd1);
        chk("fetch_addr", 64'(fetch_addr), 64'(a));
        chk("busy_fetch", 64'(busy), 64'd1);
        step;
        chk("wait_fv", 64'(fetch_valid), 64'd0);
        inst_rvalid = 1'b1;
        inst_rdata  = d;
        step;
        inst_rvalid = 1'b0;
        chk("inst_latch", 64'(inst), 64'(d));
        chk("phase0", 64'(phase), 64'd0);
    endtask

    task automatic exec_plain(input logic redir, input logic [31:0] tgt,
                              input logic halt);
        chk("wb_ph0", 64'(wb_strobe), 64'd0);
        step;
        chk("phase1", 64'(phase), 64'd1);
        chk("wb_ph1", 64'(wb_strobe), 64'd1);
        step;
        chk("phase2", 64'(phase), 64'd2);
        chk("wb_ph2", 64'(wb_strobe), 64'd0);
        redirect_en     = redir;
        redirect_target = tgt;
        halt_req        = halt;
        step;
        redirect_en = 1'b0;
        halt_req    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; fetch_ready = 1'b1; inst_rvalid = 1'b0;
        inst_rdata = '0; stall = 1'b0; redirect_en = 1'b0;
        redirect_target = '0; halt_req = 1'b0;
        r4 = 1'b1; fr4 = 1'b0; rv4 = 1'b0;

        step;
        step;
        chk("rst_pc", 64'(pc), 64'h8000_0000);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_phase", 64'(phase), 64'd0);
        chk("rst_retire", 64'(retire_count), 64'd0);
        chk("rst_fv", 64'(fetch_valid), 64'd0);
        chk("rst_wb", 64'(wb_strobe), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_err", 64'(misalign_err), 64'd0);
        chk("rst_ppi", 64'(pc_plus_inc), 64'h8000_0004);

        rst = 1'b0;
        step;
        fetch_seq(32'h8000_0000, 32'h00A0_0093);
        exec_plain(1'b0, 32'h0, 1'b0);
        chk("retire1", 64'(retire_count), 64'd1);
        fetch_seq(32'h8000_0004, 32'h0010_8113);
        exec_plain(1'b0, 32'h0, 1'b0);
        fetch_seq(32'h8000_0008, 32'h0020_8193);
        exec_plain(1'b0, 32'h0, 1'b0);
        chk("retire3", 64'(retire_count), 64'd3);
        chk("pc3", 64'(pc), 64'h8000_000C);

        fetch_seq(32'h8000_000C, 32'h0F40_006F);
        exec_plain(1'b1, 32'h8000_0100, 1'b0);
        chk("redir_pc", 64'(pc), 64'h8000_0100);

        fetch_seq(32'h8000_0100, 32'h0000_0013);
        redirect_en = 1'b1; redirect_target = 32'h8000_0200;
        halt_req = 1'b1;
        step;
        redirect_en = 1'b0; halt_req = 1'b0;
        step;
        step;
        chk("early_redir", 64'(pc), 64'h8000_0104);
        chk("early_halt", 64'(halted), 64'd0);
        chk("retire5", 64'(retire_count), 64'd5);

        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("held_fv", 64'(fetch_valid), 64'd1);
            chk("held_addr", 64'(fetch_addr), 64'h8000_0104);
            step;
        end
        fetch_ready = 1'b1;
        fetch_seq(32'h8000_0104, 32'h0000_0033);
        step;
        stall = 1'b1;
        #1;
        chk("stall_ph_a", 64'(phase), 64'd1);
        chk("stall_wb_a", 64'(wb_strobe), 64'd0);
        step;
        chk("stall_ph_b", 64'(phase), 64'd1);
        chk("stall_wb_b", 64'(wb_strobe), 64'd0);
        chk("stall_pc", 64'(pc), 64'h8000_0104);
        stall = 1'b0;
        #1;
        chk("unstall_wb", 64'(wb_strobe), 64'd1);
        step;
        chk("unstall_ph2", 64'(phase), 64'd2);
        step;
        chk("stall_pc_next", 64'(pc), 64'h8000_0108);
        chk("retire6", 64'(retire_count), 64'd6);

        fetch_seq(32'h8000_0108, 32'h0000_0063);
        exec_plain(1'b1, 32'h8000_0102, 1'b0);
        chk("mis_err", 64'(misalign_err), 64'd1);
        chk("mis_pc", 64'(pc), 64'h8000_0108);
        chk("mis_retire", 64'(retire_count), 64'd6);
        chk("mis_busy", 64'(busy), 64'd0);
        step;
        chk("mis_fv", 64'(fetch_valid), 64'd0);
        chk("mis_sticky", 64'(misalign_err), 64'd1);
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("mis_rst_pc", 64'(pc), 64'h8000_0000);
        chk("mis_rst_err", 64'(misalign_err), 64'd0);
        chk("mis_rst_rc", 64'(retire_count), 64'd0);

        step;
        fetch_seq(32'h8000_0000, 32'h0010_0073);
        exec_plain(1'b0, 32'h0, 1'b1);
        chk("halt_flag", 64'(halted), 64'd1);
        chk("halt_pc", 64'(pc), 64'h8000_0004);
        chk("halt_rc", 64'(retire_count), 64'd1);
        step;
        step;
        chk("halt_fv", 64'(fetch_valid), 64'd0);
        chk("halt_stay", 64'(halted), 64'd1);

        rst = 1'b1;
        step;
        rst = 1'b0;
        step;
        chk("rs_fv", 64'(fetch_valid), 64'd1);
        chk("rs_addr", 64'(fetch_addr), 64'h8000_0000);
        step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        inst_rvalid = 1'b1;
        inst_rdata  = 32'hDEAD_BEEF;
        step;
        chk("late_inst", 64'(inst), 64'd0);
        chk("late_fv", 64'(fetch_valid), 64'd1);
        chk("late_addr", 64'(fetch_addr), 64'h8000_0000);
        fetch_ready = 1'b0;
        step;
        chk("late_inst2", 64'(inst), 64'd0);
        chk("late_fv2", 64'(fetch_valid), 64'd1);
        inst_rvalid = 1'b0;
        fetch_ready = 1'b1;

        r4 = 1'b0;
        step;
        chk("p4_fv", 64'(fv4), 64'd1);
        fr4 = 1'b1;
        step;
        fr4 = 1'b0;
        rv4 = 1'b1;
        step;
        rv4 = 1'b0;
        chk("p4_ph0", 64'(ph4), 64'd0);
        chk("p4_wb0", 64'(wb4), 64'd0);
        step;
        chk("p4_wb1", 64'(wb4), 64'd0);
        step;
        chk("p4_wb2", 64'(wb4), 64'd0);
        step;
        chk("p4_ph3", 64'(ph4), 64'd3);
        chk("p4_wb3", 64'(wb4), 64'd1);
        chk("p4_pc_old", 64'(pc4), 64'h8000_0000);
        chk("p4_fv3", 64'(fv4), 64'd0);
        step;
        chk("p4_period_fv", 64'(fv4), 64'd1);
        chk("p4_pc_new", 64'(pc4), 64'h8000_0004);
        chk("p4_rc", 64'(rc4), 64'd1);
        chk("p4_wb_after", 64'(wb4), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
